lsu_hs: RTL

LSU_HS -- requirements
Module: lsu_hs

---
 rtl/lsu_pkg.sv | 21 ++
 rtl/lsu_lane.sv | 53 +++++
 rtl/lsu_hs.sv | 128 ++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit handshake block:
// size encodings, FSM state type and the size-to-byte-count helper.
package lsu_pkg;

  localparam logic [1:0] SIZE_BYTE   = 2'd0;
  localparam logic [1:0] SIZE_HALF   = 2'd1;
  localparam logic [1:0] SIZE_WORD   = 2'd2;
  localparam logic [1:0] SIZE_DOUBLE = 2'd3;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_REQ  = 2'd1,
    MEM_WAIT = 2'd2,
    RSP      = 2'd3
  } lsu_state_e;

  function automatic logic [3:0] size_bytes(input logic [1:0] size);
    return 4'd1 << size;
  endfunction

endpackage

// File: rtl/lsu_lane.sv
// Combinational lane steering: byte enables, store data shift and
// load data extraction with sign/zero extension.
module lsu_lane
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [1:0]                      size,
  input  logic                            is_unsigned,
  input  logic [$clog2(DATA_WIDTH/8)-1:0] offset,
  input  logic [DATA_WIDTH-1:0]           wdata,
  input  logic [DATA_WIDTH-1:0]           rdata,
  output logic [DATA_WIDTH/8-1:0]         be,
  output logic [DATA_WIDTH-1:0]           wdata_lane,
  output logic [DATA_WIDTH-1:0]           rdata_ext
);

  localparam int unsigned NB = DATA_WIDTH / 8;

  logic [3:0]            nbytes;
  logic [NB-1:0]         be_base;
  logic [DATA_WIDTH-1:0] keep;
  logic [DATA_WIDTH-1:0] rshift;
  logic                  sign;

  always_comb begin
    nbytes = size_bytes(size);
    // Clamp so an illegal double on a narrow bus never selects past the MSB.
    if (32'(nbytes) > NB) nbytes = 4'(NB);

    be_base = '0;
    for (int unsigned i = 0; i < NB; i++) begin
      if (i < 32'(nbytes)) be_base[i] = 1'b1;
    end

    keep = '0;
    for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
      if (i < 32'(nbytes) * 8) keep[i] = 1'b1;
    end

    rshift = rdata >> {offset, 3'b000};

    sign = 1'b0;
    for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
      if (i == 32'(nbytes) * 8 - 1) sign = rshift[i];
    end

    be         = be_base << offset;
    wdata_lane = wdata << {offset, 3'b000};
    rdata_ext  = (rshift & keep) | ((sign & ~is_unsigned) ? ~keep : '0);
  end

endmodule

// File: rtl/lsu_hs.sv
// Single-outstanding load/store unit: request capture, memory handshake,
// response hold. Lane steering lives in lsu_lane.
module lsu_hs
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic                      req_we_i,
  input  logic [1:0]                req_size_i,
  input  logic                      req_unsigned_i,
  input  logic [ADDR_WIDTH-1:0]     req_addr_i,
  input  logic [DATA_WIDTH-1:0]     req_wdata_i,
  output logic                      rsp_valid_o,
  input  logic                      rsp_ready_i,
  output logic [DATA_WIDTH-1:0]     rsp_rdata_o,
  output logic                      rsp_err_o,
  output logic                      mem_req_o,
  input  logic                      mem_gnt_i,
  output logic                      mem_we_o,
  output logic [DATA_WIDTH/8-1:0]   mem_be_o,
  output logic [ADDR_WIDTH-1:0]     mem_addr_o,
  output logic [DATA_WIDTH-1:0]     mem_wdata_o,
  input  logic                      mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]     mem_rdata_i
);

  localparam int unsigned NB = DATA_WIDTH / 8;
  localparam int unsigned OW = $clog2(NB);

  lsu_state_e state, state_nxt;

  logic                  we_q;
  logic                  uns_q;
  logic                  err_q;
  logic [1:0]            size_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic [OW-1:0]         req_off;
  logic [OW-1:0]         align_mask;
  logic                  req_err;
  logic                  accept;
  logic                  in_req;
  logic                  in_rsp;

  logic [NB-1:0]         lane_be;
  logic [DATA_WIDTH-1:0] lane_wdata;
  logic [DATA_WIDTH-1:0] lane_rdata;

  always_comb begin
    req_off    = req_addr_i[OW-1:0];
    align_mask = OW'(size_bytes(req_size_i) - 4'd1);
    req_err    = ((req_off & align_mask) != '0) || (32'(size_bytes(req_size_i)) > NB);
  end

  assign accept = (state == IDLE) && req_valid_i;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (req_valid_i)  state_nxt = req_err ? RSP : MEM_REQ;
      MEM_REQ:  if (mem_gnt_i)    state_nxt = we_q ? RSP : MEM_WAIT;
      MEM_WAIT: if (mem_rvalid_i) state_nxt = RSP;
      RSP:      if (rsp_ready_i)  state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        we_q    <= req_we_i;
        uns_q   <= req_unsigned_i;
        err_q   <= req_err;
        size_q  <= req_size_i;
        addr_q  <= req_addr_i;
        wdata_q <= req_wdata_i;
        rdata_q <= '0;
      end
      if (state == MEM_WAIT && mem_rvalid_i) rdata_q <= lane_rdata;
    end
  end

  lsu_lane #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_lane (
    .size        (size_q),
    .is_unsigned (uns_q),
    .offset      (addr_q[OW-1:0]),
    .wdata       (wdata_q),
    .rdata       (mem_rdata_i),
    .be          (lane_be),
    .wdata_lane  (lane_wdata),
    .rdata_ext   (lane_rdata)
  );

  assign in_req = (state == MEM_REQ);
  assign in_rsp = (state == RSP);

  // Outputs are gated by state so idle/reset values are zero regardless of
  // what the capture registers last held.
  assign req_ready_o = (state == IDLE);
  assign rsp_valid_o = in_rsp;
  assign rsp_err_o   = in_rsp & err_q;
  assign rsp_rdata_o = in_rsp ? rdata_q : '0;
  assign mem_req_o   = in_req;
  assign mem_we_o    = in_req & we_q;
  assign mem_be_o    = in_req ? lane_be : '0;
  assign mem_addr_o  = in_req ? {addr_q[ADDR_WIDTH-1:OW], {OW{1'b0}}} : '0;
  assign mem_wdata_o = in_req ? lane_wdata : '0;

endmodule
